psm_io_hub: RTL and testbench

Parametrised PicoBlaze (KCPSM6) port-mapped I/O hub, the generalised successor to the fixed bot interface between the CPU and the Rojobot/board peripherals. It provides NUM_IN snapshot-coherent input registers, NUM_OUT writable output registers, and an interrupt latch driven by the system-register update pulse. The hub sits between the KCPSM6 port bus and the peripheral blocks: bot, debounce and seven-segment display.

---
 rtl/psm_io_hub.sv | 145 ++++++++++++++
 tb/tb_psm_io_hub.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/psm_io_hub.sv
// psm_io_hub: KCPSM6 port-mapped I/O hub.
//   - NUM_IN shadow input registers, loaded together on an accepted update
//     pulse so that interrupt-service reads see one coherent snapshot.
//   - NUM_OUT writable output registers at OUT_BASE..OUT_BASE+NUM_OUT-1.
//   - Interrupt latch (IDLE/PEND) driven by upd_sysregs / interrupt_ack.
// Optional feature macro: PSM_IO_HUB_MISSCNT_EN adds a saturating 8-bit
// counter of dropped updates, readable at MISS_PORT and cleared by any write
// to MISS_PORT.
module psm_io_hub #(
    parameter int         NUM_IN    = 8,
    parameter int         NUM_OUT   = 8,
    parameter logic [7:0] OUT_BASE  = 8'h10,
    parameter logic [7:0] MISS_PORT = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           port_id,
    input  logic [7:0]           out_port,
    input  logic                 write_strobe,
    input  logic                 k_write_strobe,
    input  logic                 read_strobe,
    output logic [7:0]           in_port,
    output logic                 interrupt,
    input  logic                 interrupt_ack,
    input  logic                 upd_sysregs,
    input  logic [NUM_IN*8-1:0]  in_data,
    output logic [NUM_OUT*8-1:0] out_data
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_next_s;
    logic       accept_s;
    logic       drop_s;
    logic       wr_en_s;
    logic [7:0] shadow_r [NUM_IN];
    logic [7:0] out_r    [NUM_OUT];
    logic [7:0] rd_data_s;
    logic [7:0] in_port_r;

    // read_strobe carries no decode meaning here: the read mux runs every cycle.
    logic unused_s;
    assign unused_s = read_strobe;

    // An update is taken when nothing is pending, or when the pending one is
    // being acknowledged in the same cycle; otherwise it is dropped.
    assign accept_s = upd_sysregs & ((state_r == IDLE) | interrupt_ack);
    assign drop_s   = upd_sysregs & ~accept_s;
    assign wr_en_s  = write_strobe | k_write_strobe;

    // Interrupt latch next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_next_s = PEND;
                else          state_next_s = IDLE;
            end
            PEND: begin
                if (interrupt_ack && !upd_sysregs) state_next_s = IDLE;
                else                               state_next_s = PEND;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Interrupt latch state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= IDLE;
        else        state_r <= state_next_s;
    end

    assign interrupt = (state_r == PEND);

    // Snapshot all live input bytes on an accepted update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_IN; k++) shadow_r[k] <= 8'h00;
        end else if (accept_s) begin
            for (int k = 0; k < NUM_IN; k++) shadow_r[k] <= in_data[8*k +: 8];
        end else begin
            for (int k = 0; k < NUM_IN; k++) shadow_r[k] <= shadow_r[k];
        end
    end

    // Output register write decode; both strobe kinds behave the same.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_OUT; k++) out_r[k] <= 8'h00;
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (wr_en_s && (port_id == (OUT_BASE + 8'(k)))) out_r[k] <= out_port;
                else                                            out_r[k] <= out_r[k];
            end
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign out_data[8*g +: 8] = out_r[g];
    end

`ifdef PSM_IO_HUB_MISSCNT_EN
    logic [7:0] miss_r;
    logic       miss_clr_s;

    assign miss_clr_s = wr_en_s & (port_id == MISS_PORT);

    // Saturating count of dropped updates; a clear coinciding with a drop
    // still records that drop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                             miss_r <= 8'h00;
        else if (miss_clr_s && drop_s)          miss_r <= 8'h01;
        else if (miss_clr_s)                    miss_r <= 8'h00;
        else if (drop_s && (miss_r != 8'hFF))   miss_r <= miss_r + 8'h01;
        else                                    miss_r <= miss_r;
    end
`else
    logic unused_drop_s;
    assign unused_drop_s = drop_s;
`endif

    // Read mux: shadow bytes, optional miss counter, zero elsewhere.
    always_comb begin
        rd_data_s = 8'h00;
        for (int k = 0; k < NUM_IN; k++) begin
            rd_data_s = (port_id == 8'(k)) ? shadow_r[k] : rd_data_s;
        end
`ifdef PSM_IO_HUB_MISSCNT_EN
        rd_data_s = (port_id == MISS_PORT) ? miss_r : rd_data_s;
`endif
    end

    // Registered read data, refreshed every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) in_port_r <= 8'h00;
        else        in_port_r <= rd_data_s;
    end

    assign in_port = in_port_r;

endmodule

// File: tb/tb_psm_io_hub.sv
// Self-checking bench for psm_io_hub: directed scenarios followed by random
// traffic, all compared against a behavioural model of the hub.
module tb_psm_io_hub;

    localparam int         NI = 8;
    localparam int         NO = 8;
    localparam logic [7:0] OB = 8'h10;
    localparam logic [7:0] MP = 8'hFF;
`ifdef PSM_IO_HUB_MISSCNT_EN
    localparam bit MISS_EN = 1'b1;
`else
    localparam bit MISS_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      port_id;
    logic [7:0]      out_port;
    logic            ws;
    logic            kws;
    logic            rs;
    logic [7:0]      in_port;
    logic            interrupt;
    logic            ack;
    logic            upd;
    logic [NI*8-1:0] in_data;
    logic [NO*8-1:0] out_data;

    psm_io_hub #(.NUM_IN(NI), .NUM_OUT(NO), .OUT_BASE(OB), .MISS_PORT(MP)) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
        .write_strobe(ws), .k_write_strobe(kws), .read_strobe(rs),
        .in_port(in_port), .interrupt(interrupt), .interrupt_ack(ack),
        .upd_sysregs(upd), .in_data(in_data), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit         m_int;
    logic [7:0] m_sh  [NI];
    logic [7:0] m_out [NO];
    int         m_miss;
    logic [7:0] m_inport;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [NO*8-1:0] m_out_vec();
        logic [NO*8-1:0] v;
        for (int k = 0; k < NO; k++) v[8*k +: 8] = m_out[k];
        return v;
    endfunction

    task automatic model_reset();
        m_int = 1'b0; m_miss = 0; m_inport = 8'h00;
        for (int k = 0; k < NI; k++) m_sh[k] = 8'h00;
        for (int k = 0; k < NO; k++) m_out[k] = 8'h00;
    endtask

    // Apply the hub's rules for one clock edge using the currently driven inputs.
    task automatic model_edge();
        int p;
        bit wr, accept, drop;
        p      = int'(port_id);
        wr     = ws | kws;
        accept = upd && (!m_int || ack);
        drop   = upd && !accept;
        if (p < NI)                 m_inport = m_sh[p];
        else if (MISS_EN && p == MP) m_inport = 8'(m_miss);
        else                        m_inport = 8'h00;
        if (accept) begin
            for (int k = 0; k < NI; k++) m_sh[k] = in_data[8*k +: 8];
            m_int = 1'b1;
        end else if (m_int && ack) begin
            m_int = 1'b0;
        end
        if (wr && p >= OB && p < OB + NO) m_out[p - OB] = out_port;
        if (MISS_EN) begin
            if (wr && p == MP)            m_miss = drop ? 1 : 0;
            else if (drop && m_miss < 255) m_miss++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("interrupt", interrupt, m_int);
        check("in_port", in_port, m_inport);
        check("out_data", out_data, m_out_vec());
    endtask

    task automatic idle_inputs();
        port_id = 8'h00; out_port = 8'h00; ws = 1'b0; kws = 1'b0; rs = 1'b0;
        ack = 1'b0; upd = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        in_data = '0;
        model_reset();
        #12;
        check("reset_int", interrupt, 1'b0);
        check("reset_in_port", in_port, 8'h00);
        check("reset_out", out_data, '0);
        @(negedge clk); #2 reset = 1'b1;
        step();

        // Snapshot coherence
        in_data = {$urandom, $urandom};
        in_data[23:16] = 8'h3C;
        upd = 1'b1; step(); upd = 1'b0;
        check("snap_int", interrupt, 1'b1);
        in_data[23:16] = 8'h99; port_id = 8'd2;
        step();
        check("snap_port2", in_port, 8'h3C);

        // Dropped update
        upd = 1'b1; step(); upd = 1'b0;
        step();
        check("drop_port2", in_port, 8'h3C);
        port_id = MP; step();
        check("drop_miss", in_port, MISS_EN ? 8'h01 : 8'h00);

        // Ack plus update together, then a lone ack
        ack = 1'b1; upd = 1'b1; port_id = 8'd2; step(); ack = 1'b0; upd = 1'b0;
        check("ackupd_int", interrupt, 1'b1);
        step();
        check("ackupd_port2", in_port, 8'h99);
        ack = 1'b1; step(); ack = 1'b0;
        check("ack_int", interrupt, 1'b0);
        ack = 1'b1; step(); ack = 1'b0;
        check("ack_idle_int", interrupt, 1'b0);

        // Write decode
        port_id = 8'h13; out_port = 8'h5A; ws = 1'b1; step(); ws = 1'b0;
        check("wr_13", out_data[31:24], 8'h5A);
        port_id = 8'h17; out_port = 8'hC3; kws = 1'b1; step(); kws = 1'b0;
        check("kwr_17", out_data[63:56], 8'hC3);
        port_id = 8'h18; out_port = 8'h77; ws = 1'b1; step(); ws = 1'b0;
        check("wr_18_ignored", out_data, {8'hC3, 24'h0, 8'h5A, 24'h0});
        port_id = 8'h40; step();
        check("rd_40", in_port, 8'h00);

        // Write and accepted update in the same cycle
        port_id = 8'h10; out_port = 8'hA5; ws = 1'b1; upd = 1'b1; step();
        ws = 1'b0; upd = 1'b0;
        check("wr_upd_int", interrupt, 1'b1);
        check("wr_upd_out0", out_data[7:0], 8'hA5);

        // Asynchronous reset mid-ISR
        #2 reset = 1'b0;
        #1;
        check("async_rst_int", interrupt, 1'b0);
        check("async_rst_out", out_data, '0);
        check("async_rst_in_port", in_port, 8'h00);
        model_reset();
        @(posedge clk); #1;
        check("rst_hold_int", interrupt, 1'b0);
        check("rst_hold_out", out_data, '0);
        #2 reset = 1'b1;
        step();

        // Counter saturation
        in_data = {$urandom, $urandom};
        upd = 1'b1; step();
        port_id = MP;
        for (int i = 0; i < 300; i++) step();
        upd = 1'b0; step();
        check("miss_sat", in_port, MISS_EN ? 8'hFF : 8'h00);
        ws = 1'b1; out_port = 8'h3F; step(); ws = 1'b0;
        step();
        check("miss_clr", in_port, 8'h00);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            in_data  = {$urandom, $urandom};
            upd      = ($urandom_range(0, 3) == 0);
            ack      = ($urandom_range(0, 4) == 0);
            ws       = ($urandom_range(0, 4) == 0);
            kws      = ($urandom_range(0, 6) == 0);
            rs       = $urandom_range(0, 1);
            out_port = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       port_id = 8'($urandom_range(0, NI - 1));
                1:       port_id = OB + 8'($urandom_range(0, NO));
                2:       port_id = MP;
                default: port_id = 8'($urandom);
            endcase
            step();
        end
        idle_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
